// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - stall bus layout, hold patterns and divider FSM encodings
package pipeline_ctrl_pkg;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_BUS = 5;

   // Each pattern holds its own stage and everything upstream of it.
   localparam logic [STALL_BUS-1:0] HOLD_NONE = 5'b00000;
   localparam logic [STALL_BUS-1:0] HOLD_ID   = 5'b00111;
   localparam logic [STALL_BUS-1:0] HOLD_EX   = 5'b01111;
   localparam logic [STALL_BUS-1:0] HOLD_ALL  = 5'b11111;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/pipeline_ctrl_div_sequencer.sv
// rtl/pipeline_ctrl_div_sequencer.sv - RUN/BUSY/DONE sequencing of the iterative HI/LO divider
module div_sequencer
   import pipeline_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic ex_div,
   input  logic exc_flush,
   input  logic hold_ex,
   output logic div_start,
   output logic div_done,
   output logic div_abort,
   output logic div_busy,
   output logic div_stall
);

   localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

   div_state_t       state;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_RUN;
         count <= '0;
      end else if (exc_flush) begin
         state <= ST_RUN;
         count <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (ex_div) begin
                  state <= ST_BUSY;
                  count <= CNT_LOAD;
               end
            end
            ST_BUSY: begin
               // Counting is independent of memory wait states.
               if (count == '0) state <= ST_DONE;
               else             count <= count - 1'b1;
            end
            ST_DONE: begin
               // Stay until the finished DIV actually leaves EX.
               if (!hold_ex) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   always_comb begin
      div_start = rst && (state == ST_RUN) && ex_div && !exc_flush;
      div_done  = rst && (state == ST_BUSY) && (count == '0) && !exc_flush;
      div_abort = rst && (state == ST_BUSY) && exc_flush;
      div_busy  = rst && (state == ST_BUSY);
      div_stall = rst && (((state == ST_RUN) && ex_div) || (state == ST_BUSY));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard priority mux driving stage holds, bubbles and flush
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_read_en_1,
   input  logic                  id_read_en_2,
   input  logic [REG_ADDR_W-1:0] id_read_addr_1,
   input  logic [REG_ADDR_W-1:0] id_read_addr_2,
   input  logic                  id_mfc0,
   input  logic [REG_ADDR_W-1:0] id_cp0_addr,
   input  logic                  ex_load,
   input  logic [REG_ADDR_W-1:0] ex_write_addr,
   input  logic                  ex_mtc0,
   input  logic                  mem_mtc0,
   input  logic [REG_ADDR_W-1:0] ex_cp0_addr,
   input  logic [REG_ADDR_W-1:0] mem_cp0_addr,
   input  logic                  ex_div,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   input  logic                  exc_flush,
   output logic [STALL_BUS-1:0]  stall,
   output logic                  id_bubble,
   output logic                  ex_bubble,
   output logic                  mem_bubble,
   output logic                  flush,
   output logic                  div_start,
   output logic                  div_done,
   output logic                  div_abort,
   output logic                  div_busy
);

   logic mem_wait;
   logic div_stall;
   logic cp0_hazard;
   logic load_use;

   assign mem_wait   = mem_req && !mem_ready;
   assign cp0_hazard = id_mfc0 &&
                       ((ex_mtc0  && (ex_cp0_addr  == id_cp0_addr)) ||
                        (mem_mtc0 && (mem_cp0_addr == id_cp0_addr)));
   // $0 is hardwired, so a load targeting it never produces a value to wait for.
   assign load_use   = ex_load && (ex_write_addr != '0) &&
                       ((id_read_en_1 && (id_read_addr_1 == ex_write_addr)) ||
                        (id_read_en_2 && (id_read_addr_2 == ex_write_addr)));

   div_sequencer #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_seq (
      .clk       (clk),
      .rst       (rst),
      .ex_div    (ex_div),
      .exc_flush (exc_flush),
      .hold_ex   (stall[STALL_EX]),
      .div_start (div_start),
      .div_done  (div_done),
      .div_abort (div_abort),
      .div_busy  (div_busy),
      .div_stall (div_stall)
   );

   always_comb begin
      stall      = HOLD_NONE;
      id_bubble  = 1'b0;
      ex_bubble  = 1'b0;
      mem_bubble = 1'b0;
      flush      = 1'b0;
      if (rst) begin
         if (exc_flush) begin
            flush = 1'b1;
         end else if (mem_wait) begin
            stall      = HOLD_ALL;
            mem_bubble = 1'b1;
         end else if (div_stall) begin
            stall     = HOLD_EX;
            ex_bubble = 1'b1;
         end else if (cp0_hazard || load_use) begin
            stall     = HOLD_ID;
            id_bubble = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - vector table plus scoreboarded sequences for pipeline_ctrl
module tb_pipeline_ctrl;

   localparam int DIVC = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_read_en_1, id_read_en_2;
   logic [4:0] id_read_addr_1, id_read_addr_2;
   logic       id_mfc0;
   logic [4:0] id_cp0_addr;
   logic       ex_load;
   logic [4:0] ex_write_addr;
   logic       ex_mtc0, mem_mtc0;
   logic [4:0] ex_cp0_addr, mem_cp0_addr;
   logic       ex_div, mem_req, mem_ready, exc_flush;
   logic [4:0] stall;
   logic       id_bubble, ex_bubble, mem_bubble, flush;
   logic       div_start, div_done, div_abort, div_busy;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       rst;
      logic       re1;
      logic [4:0] ra1;
      logic       re2;
      logic [4:0] ra2;
      logic       mfc0;
      logic [4:0] cp0a;
      logic       ld;
      logic [4:0] wa;
      logic       exm;
      logic [4:0] exa;
      logic       memm;
      logic [4:0] mema;
      logic       div;
      logic       mreq;
      logic       mrdy;
      logic       fl;
   } in_t;

   typedef struct {
      string       name;
      in_t         in;
      logic [12:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [12:0] exp_q[$];
   string       name_q[$];

   localparam logic [4:0] S_ID  = 5'b00111;
   localparam logic [4:0] S_DIV = 5'b01111;
   localparam logic [4:0] S_ALL = 5'b11111;

   pipeline_ctrl #(.DIV_CYCLES(DIVC), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_read_en_1   (id_read_en_1),
      .id_read_en_2   (id_read_en_2),
      .id_read_addr_1 (id_read_addr_1),
      .id_read_addr_2 (id_read_addr_2),
      .id_mfc0        (id_mfc0),
      .id_cp0_addr    (id_cp0_addr),
      .ex_load        (ex_load),
      .ex_write_addr  (ex_write_addr),
      .ex_mtc0        (ex_mtc0),
      .mem_mtc0       (mem_mtc0),
      .ex_cp0_addr    (ex_cp0_addr),
      .mem_cp0_addr   (mem_cp0_addr),
      .ex_div         (ex_div),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .exc_flush      (exc_flush),
      .stall          (stall),
      .id_bubble      (id_bubble),
      .ex_bubble      (ex_bubble),
      .mem_bubble     (mem_bubble),
      .flush          (flush),
      .div_start      (div_start),
      .div_done       (div_done),
      .div_abort      (div_abort),
      .div_busy       (div_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] exp_o(input logic [4:0] s, input logic idb, input logic exb,
                                         input logic memb, input logic fl, input logic ds,
                                         input logic dd, input logic da, input logic bz);
      return {s, idb, exb, memb, fl, ds, dd, da, bz};
   endfunction

   function automatic in_t idle();
      in_t v;
      v = '0;
      v.rst = 1'b1;
      return v;
   endfunction

   task automatic apply(input in_t v);
      rst            = v.rst;
      id_read_en_1   = v.re1;
      id_read_addr_1 = v.ra1;
      id_read_en_2   = v.re2;
      id_read_addr_2 = v.ra2;
      id_mfc0        = v.mfc0;
      id_cp0_addr    = v.cp0a;
      ex_load        = v.ld;
      ex_write_addr  = v.wa;
      ex_mtc0        = v.exm;
      ex_cp0_addr    = v.exa;
      mem_mtc0       = v.memm;
      mem_cp0_addr   = v.mema;
      ex_div         = v.div;
      mem_req        = v.mreq;
      mem_ready      = v.mrdy;
      exc_flush      = v.fl;
   endtask

   task automatic check_front();
      logic [12:0] exp;
      logic [12:0] got;
      string       nm;
      got = {stall, id_bubble, ex_bubble, mem_bubble, flush,
             div_start, div_done, div_abort, div_busy};
      if (exp_q.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_empty got=%b", got);
      end else begin
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s got stall=%b idb/exb/memb/fl=%b start/done/abort/busy=%b required stall=%b idb/exb/memb/fl=%b start/done/abort/busy=%b",
                     nm, got[12:8], got[7:4], got[3:0], exp[12:8], exp[7:4], exp[3:0]);
         end
      end
   endtask

   // One cycle: drive at posedge+1, sample at the following negedge.
   task automatic step(input string nm, input in_t v, input logic [12:0] exp);
      apply(v);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(negedge clk);
      check_front();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string nm, input in_t v, input logic [12:0] exp);
      vec_t r;
      r.name = nm;
      r.in   = v;
      r.exp  = exp;
      vecs.push_back(r);
   endtask

   initial begin
      in_t         v;
      logic [12:0] e_id, e_mem, e_fl;
      e_id  = exp_o(S_ID, 1, 0, 0, 0, 0, 0, 0, 0);
      e_mem = exp_o(S_ALL, 0, 0, 1, 0, 0, 0, 0, 0);
      e_fl  = exp_o(5'b0, 0, 0, 0, 1, 0, 0, 0, 0);

      v = idle();                                               add("idle", v, '0);
      v = idle(); v.ld=1; v.wa=8; v.re2=1; v.ra2=8;             add("lu_port2", v, e_id);
      v = idle(); v.ld=1; v.wa=0; v.re2=1; v.ra2=0;             add("lu_reg0", v, '0);
      v = idle(); v.ld=1; v.wa=9; v.re1=0; v.ra1=9;             add("lu_port1_disabled", v, '0);
      v = idle(); v.ld=1; v.wa=9; v.re1=1; v.ra1=9;             add("lu_port1", v, e_id);
      v = idle(); v.ld=0; v.wa=9; v.re1=1; v.ra1=9;             add("no_load", v, '0);
      v = idle(); v.ld=1; v.wa=9; v.re1=1; v.ra1=10;            add("lu_addr_differs", v, '0);
      v = idle(); v.mfc0=1; v.cp0a=12; v.memm=1; v.mema=12;     add("cp0_mem", v, e_id);
      v = idle(); v.mfc0=1; v.cp0a=12; v.exm=1; v.exa=12;       add("cp0_ex", v, e_id);
      v = idle(); v.mfc0=1; v.cp0a=0; v.exm=1; v.exa=0;         add("cp0_reg0", v, e_id);
      v = idle(); v.mfc0=1; v.cp0a=12; v.exm=1; v.exa=13;       add("cp0_addr_differs", v, '0);
      v = idle(); v.mfc0=0; v.cp0a=12; v.exm=1; v.exa=12;       add("cp0_no_mfc0", v, '0);
      v = idle(); v.mreq=1; v.mrdy=0;                           add("memwait", v, e_mem);
      v = idle(); v.mreq=1; v.mrdy=1;                           add("mem_ready", v, '0);
      v = idle(); v.mreq=1; v.ld=1; v.wa=8; v.re2=1; v.ra2=8;   add("memwait_over_lu", v, e_mem);
      v = idle(); v.mreq=1; v.fl=1;                             add("flush_over_memwait", v, e_fl);
      v = idle(); v.fl=1; v.ld=1; v.wa=8; v.re1=1; v.ra1=8;     add("flush_over_lu", v, e_fl);
      v = idle(); v.fl=1; v.div=1;                              add("flush_blocks_start", v, e_fl);

      // Reset: hazards present but everything held at zero.
      v = idle(); v.rst=0; v.mreq=1; v.ld=1; v.wa=8; v.re2=1; v.ra2=8; v.div=1;
      step("reset0", v, '0);
      step("reset1", v, '0);

      foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp);

      // Load-use resolves after exactly one bubble.
      v = idle(); v.ld=1; v.wa=8; v.re2=1; v.ra2=8;
      step("lu_seq_stall", v, e_id);
      v.ld = 0;
      step("lu_seq_release", v, '0);

      // MTC0 in EX then MEM costs two cycles.
      v = idle(); v.mfc0=1; v.cp0a=12; v.exm=1; v.exa=12;
      step("cp0_seq_ex", v, e_id);
      v.exm=0; v.memm=1; v.mema=12;
      step("cp0_seq_mem", v, e_id);
      v.memm=0;
      step("cp0_seq_clear", v, '0);

      // Plain DIV: DIVC+1 stalled cycles, done in the last, no restart in DONE.
      v = idle(); v.div=1;
      step("div_start", v, exp_o(S_DIV, 0, 1, 0, 0, 1, 0, 0, 0));
      for (int c = 1; c <= DIVC; c++)
         step($sformatf("div_busy_c%0d", c), v, exp_o(S_DIV, 0, 1, 0, 0, 0, (c == DIVC), 0, 1));
      step("div_done_no_restart", v, '0);
      v.div = 0;
      step("div_back_to_run", v, '0);

      // MEMWAIT from count 5: counting continues, then DONE waits out MEMWAIT.
      v = idle(); v.div=1;
      step("dmw_start", v, exp_o(S_DIV, 0, 1, 0, 0, 1, 0, 0, 0));
      for (int c = 1; c <= 26; c++)
         step($sformatf("dmw_busy_c%0d", c), v, exp_o(S_DIV, 0, 1, 0, 0, 0, 0, 0, 1));
      v.mreq = 1;
      for (int c = 27; c <= 36; c++)
         step($sformatf("dmw_wait_c%0d", c), v, exp_o(S_ALL, 0, 0, 1, 0, 0, (c == 32), 0, (c <= 32)));
      v.mrdy = 1;
      step("dmw_release", v, '0);
      v = idle();
      step("dmw_idle", v, '0);

      // Flush while BUSY aborts the divide.
      v = idle(); v.div=1;
      step("dfl_start", v, exp_o(S_DIV, 0, 1, 0, 0, 1, 0, 0, 0));
      for (int c = 1; c <= 3; c++)
         step($sformatf("dfl_busy_c%0d", c), v, exp_o(S_DIV, 0, 1, 0, 0, 0, 0, 0, 1));
      v.fl = 1;
      step("dfl_flush", v, exp_o(5'b0, 0, 0, 0, 1, 0, 0, 1, 1));
      v = idle();
      step("dfl_after", v, '0);

      // Reset while BUSY, then a fresh start once released.
      v = idle(); v.div=1;
      step("drst_start", v, exp_o(S_DIV, 0, 1, 0, 0, 1, 0, 0, 0));
      for (int c = 1; c <= 4; c++)
         step($sformatf("drst_busy_c%0d", c), v, exp_o(S_DIV, 0, 1, 0, 0, 0, 0, 0, 1));
      v.rst = 0;
      step("drst_in_reset", v, '0);
      v.rst = 1;
      step("drst_restart", v, exp_o(S_DIV, 0, 1, 0, 0, 1, 0, 0, 0));
      step("drst_busy_again", v, exp_o(S_DIV, 0, 1, 0, 0, 0, 0, 0, 1));
      v = idle(); v.fl = 1;
      step("drst_abort", v, exp_o(5'b0, 0, 0, 0, 1, 0, 0, 1, 1));
      v = idle();
      step("drst_idle", v, '0);

      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
